sevenseg_scan_driver: RTL and testbench
=======================================

Name: sevenseg_scan_driver

Overview:
- Time-multiplexed driver for NUM_DIGITS common-anode/cathode seven-segment digits, each fed by a 4-bit BCD code.
- Successor to the single-digit combinational decoder; adds:
  - parametrised digit count;
  - clocked digit scanning with inter-digit ghost blanking;
  - a double-buffered load interface so a displayed frame never tears.
- Sits between the board's user logic (counters, GPIO inputs) and the display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- CLK_DIV, 1000, clock cycles per digit slot (>= BLANK_CYCLES+1).
- BLANK_CYCLES, 2, cycles at the start of each slot with all digit enables off.
- SEG_ACTIVE_LOW, 1, 1: segment/dp pins drive 0 to light; 0: drive 1 to light.
- DIG_ACTIVE_LOW, 1, 1: digit enable pins are active-low; 0: active-high.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- digits_in  input  4*NUM_DIGITS  BCD codes; digit 0 is bits [3:0] and is the rightmost digit.
- dp_in  input  NUM_DIGITS  decimal-point request per digit.
- load  input  1  one-cycle strobe; captures digits_in/dp_in.
- pending  output  1  high while captured data awaits the next frame boundary.
- frame_start  output  1  one-cycle pulse when slot index wraps to 0.
- seg  output  7  segments {a,b,c,d,e,f,g}, a = MSB.
- dp  output  1  decimal-point segment.
- an  output  NUM_DIGITS  digit enables; bit k drives digit k.

Behaviour:
- Polarity. Reset state is "all off":
  - seg/dp = all 1 if SEG_ACTIVE_LOW, else all 0.
  - an = all 1 if DIG_ACTIVE_LOW, else all 0.
  - pending = 0, frame_start = 0.
  - Internal state: prescaler p = 0, slot index k = 0, display and shadow registers = 0, pending flag = 0.
- Reset is asynchronous. Asserting rst mid-frame or mid-load returns everything to reset state immediately. Any pending data is discarded.
- Prescaler:
  - p counts 0..CLK_DIV-1 and wraps.
  - tick = (p == CLK_DIV-1).
  - On tick, k increments and wraps from NUM_DIGITS-1 to 0.
  - Frame boundary = tick with k == NUM_DIGITS-1.
  - frame_start is registered: high for the one cycle after the boundary.
- Scan outputs are registered from the current (p, k, display register), so they lag state by exactly 1 cycle.
  - If p < BLANK_CYCLES: an is all off; seg/dp still carry digit k's pattern.
  - Otherwise: an enables only digit k; seg = decode(display[k]); dp = display_dp[k].
- Decode, active-high form before polarity inversion:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011.
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Codes 10-15 are blank (0000000) unless HEX_EN is defined.
- Load handshake:
  - load=1 captures digits_in/dp_in into the shadow register and sets pending.
  - At a frame boundary with pending=1, the shadow register copies to the display register and pending clears.
  - load on the boundary cycle: the new data goes directly into the display register and pending clears.
  - Repeated loads before a boundary overwrite the shadow register; the last one wins.
  - No data is ever dropped except on a superseded load.
- NUM_DIGITS=1: k stays 0; every tick is a frame boundary.

Optional Feature:
- SEVENSEG_HEX_EN defined: codes 10-15 decode as A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Not defined: codes 10-15 blank all segments, and dp still follows dp_in.

Test Plan:
- Bench setup: NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1, active-low.
- Reset: assert rst mid-slot. Immediately seg=7'b1111111, dp=1, an=4'b1111, pending=0. After release, first frame shows "0000" (seg=7'b0000001 in the enabled slots).
- Scan timing: load digits 4'h9,4'h3,4'h1,4'h7 (digit3..0). After the boundary, each slot is 4 cycles: an=1111 for 1 cycle, then 1110/1101/1011/0111 for 3 cycles. seg=0001111, 1001111, 0000110, 0000100 respectively. frame_start pulses every 16 cycles.
- Tear-free load: load 16'h1234 mid-frame. Then pending=1, and the displayed digits are unchanged until the next boundary. The cycle after the boundary: pending=0 and the new digits appear.
- Simultaneous load at boundary: load 16'h5555 on the boundary cycle. The display shows 5 in every digit in the very next frame, and pending stays 0.
- Superseded load: load 16'h1111 then 16'h2222 in the same frame. Only 2222 is ever displayed.
- Invalid codes: load 16'hABCD with dp_in=4'b0001. Without SEVENSEG_HEX_EN: seg=1111111 in all slots, dp=0 only in slot 0. With SEVENSEG_HEX_EN: seg=0001000, 1100000, 0110001, 1000010.

Source files
------------

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed BCD seven-segment scanner with ghost blanking and tear-free double-buffered loads.
// Define SEVENSEG_HEX_EN to decode codes 10-15 as A,b,C,d,E,F instead of blanking them.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  output logic                      pending,
  output logic                      frame_start,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int KW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 7'h7f : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = DIG_ACTIVE_LOW != 0 ? '1 : '0;
  logic [PW-1:0]           r_p;
  logic [KW-1:0]           r_k;
  logic [4*NUM_DIGITS-1:0] r_disp, r_shadow;
  logic [NUM_DIGITS-1:0]   r_dpd, r_sdp;
  logic                    r_pending;
  logic                    w_tick, w_klast, w_bound, w_blank;
  logic [3:0]              w_code;
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_onehot;
  assign w_tick   = r_p == PW'(CLK_DIV - 1);
  assign w_klast  = r_k == KW'(NUM_DIGITS - 1);
  assign w_bound  = w_tick && w_klast;
  assign w_blank  = r_p < PW'(BLANK_CYCLES);
  assign w_code   = r_disp[r_k*4 +: 4];
  assign w_onehot = NUM_DIGITS'(1) << r_k;
  assign pending  = r_pending;
  always_comb begin
    w_seg = 7'b0000000;
    case (w_code)
      4'd0: w_seg = 7'b1111110;
      4'd1: w_seg = 7'b0110000;
      4'd2: w_seg = 7'b1101101;
      4'd3: w_seg = 7'b1111001;
      4'd4: w_seg = 7'b0110011;
      4'd5: w_seg = 7'b1011011;
      4'd6: w_seg = 7'b1011111;
      4'd7: w_seg = 7'b1110000;
      4'd8: w_seg = 7'b1111111;
      4'd9: w_seg = 7'b1111011;
`ifdef SEVENSEG_HEX_EN
      4'd10: w_seg = 7'b1110111;
      4'd11: w_seg = 7'b0011111;
      4'd12: w_seg = 7'b1001110;
      4'd13: w_seg = 7'b0111101;
      4'd14: w_seg = 7'b1001111;
      4'd15: w_seg = 7'b1000111;
`endif
      default: w_seg = 7'b0000000;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_p         <= '0;
      r_k         <= '0;
      r_disp      <= '0;
      r_shadow    <= '0;
      r_dpd       <= '0;
      r_sdp       <= '0;
      r_pending   <= 1'b0;
      frame_start <= 1'b0;
      seg         <= SEG_OFF;
      dp          <= SEG_OFF[0];
      an          <= AN_OFF;
    end else begin
      r_p         <= w_tick ? '0 : r_p + 1'b1;
      if (w_tick) r_k <= w_klast ? '0 : r_k + 1'b1;
      frame_start <= w_bound;
      if (load) begin
        r_shadow <= digits_in;
        r_sdp    <= dp_in;
      end
      // a load landing on the boundary bypasses the shadow so it is shown in the very next frame
      if (w_bound && (load || r_pending)) begin
        r_disp <= load ? digits_in : r_shadow;
        r_dpd  <= load ? dp_in : r_sdp;
      end
      r_pending   <= load ? !w_bound : r_pending && !w_bound;
      seg         <= w_seg ^ SEG_OFF;
      dp          <= r_dpd[r_k] ^ SEG_OFF[0];
      an          <= w_blank ? AN_OFF : w_onehot ^ AN_OFF;
    end
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: directed plus random loads checked cycle-by-cycle against a frame-level display model.
module tb_sevenseg_scan_driver;
  logic        clk = 1'b0, rst = 1'b0, load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0, an;
  logic        pending, frame_start, dp;
  logic [6:0]  seg;
  int          checks = 0, errors = 0;
  int          n;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_dp, m_sdp;
  bit          m_pend;
  localparam logic [6:0] DEC [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
`ifdef SEVENSEG_HEX_EN
    7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
`else
    7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0
`endif
  };
  sevenseg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .pending(pending), .frame_start(frame_start), .seg(seg), .dp(dp), .an(an));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, n);
    end
  endtask
  // One clock: outputs after the edge reflect the slot/display state seen before it.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dv);
    int p, k;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic e_dp, bound;
    load = ld; digits_in = d; dp_in = dv;
    p = n % 4;
    k = (n / 4) % 4;
    bound = (n % 16) == 15;
    e_seg = ~DEC[m_disp[4*k +: 4]];
    e_dp = ~m_dp[k];
    e_an = p < 1 ? 4'hf : ~(4'b0001 << k);
    if (ld && bound) begin
      m_disp = d; m_dp = dv; m_pend = 0;
    end else if (ld) begin
      m_shadow = d; m_sdp = dv; m_pend = 1;
    end else if (bound && m_pend) begin
      m_disp = m_shadow; m_dp = m_sdp; m_pend = 0;
    end
    n++;
    @(posedge clk);
    #1;
    chk("seg", 16'(seg), 16'(e_seg));
    chk("dp", 16'(dp), 16'(e_dp));
    chk("an", 16'(an), 16'(e_an));
    chk("frame_start", 16'(frame_start), 16'(bound));
    chk("pending", 16'(pending), 16'(m_pend));
  endtask
  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) step(1'b0, $urandom, $urandom);
  endtask
  task automatic idle_until(input int r);
    while (n % 16 != r) step(1'b0, $urandom, $urandom);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    load = 1'b0;
    #1;
    chk("rst_seg", 16'(seg), 16'h7f);
    chk("rst_dp", 16'(dp), 16'h1);
    chk("rst_an", 16'(an), 16'hf);
    chk("rst_pending", 16'(pending), 16'h0);
    chk("rst_frame_start", 16'(frame_start), 16'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    n = 0; m_disp = '0; m_shadow = '0; m_dp = '0; m_sdp = '0; m_pend = 0;
  endtask
  initial begin
    n = 0;
    do_reset();
    idle(20);
    idle_until(5);
    step(1'b1, 16'h9317, 4'b0000);
    idle(40);
    idle_until(6);
    step(1'b1, 16'h1234, 4'b0010);
    idle(30);
    idle_until(15);
    step(1'b1, 16'h5555, 4'b1000);
    idle(20);
    idle_until(2);
    step(1'b1, 16'h1111, 4'b0000);
    step(1'b0, 16'h0, 4'b0);
    step(1'b1, 16'h2222, 4'b0100);
    idle(30);
    idle_until(3);
    step(1'b1, 16'hABCD, 4'b0001);
    idle(20);
    idle(3);
    step(1'b1, 16'h8888, 4'b1111);
    do_reset();
    idle(20);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) == 0, $urandom, $urandom);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
